// File: rtl/clint_multi_hart.sv
`default_nettype none
// ============================================================================
// Module      : clint_multi_hart
// Description : Core-local interruptor for NHART harts. Free-running 64-bit
//               mtime with prescaler, per-hart mtimecmp and msip registers,
//               AXI4-Lite read/write slave, registered mtip and direct msip.
// Revision    : 1.0 - initial multi-hart read/write release
// ============================================================================
module clint_multi_hart #(
  parameter int NHART    = 2,
  parameter int PRESCALE = 1,
  parameter int ADDR_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  // read address / data channels
  input  logic             arvalid,
  output logic             arready,
  input  logic [31:0]      araddr,
  output logic             rvalid,
  input  logic             rready,
  output logic [1:0]       rresp,
  output logic [31:0]      rdata,
  // write address / data / response channels
  input  logic             awvalid,
  output logic             awready,
  input  logic [31:0]      awaddr,
  input  logic             wvalid,
  output logic             wready,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  output logic             bvalid,
  input  logic             bready,
  output logic [1:0]       bresp,
  // interrupt lines towards the harts
  output logic [NHART-1:0] mtip,
  output logic [NHART-1:0] msip
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  localparam logic [ADDR_W-1:0] OFF_MTIME_LO = ADDR_W'(32'hBFF8);
  localparam logic [ADDR_W-1:0] OFF_MTIME_HI = ADDR_W'(32'hBFFC);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ACC  = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ACC  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // Register offsets for a given hart
  function automatic logic [ADDR_W-1:0] msip_off(input int h);
    return ADDR_W'(4 * h);
  endfunction

  function automatic logic [ADDR_W-1:0] cmp_off(input int h);
    return ADDR_W'(32'h4000 + 8 * h);
  endfunction

  // Byte-lane merge of new data into an existing 32-bit word
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // Address bits above the decoded offset are intentionally ignored
  logic unused_addr_hi;
  assign unused_addr_hi = ^{araddr[31:ADDR_W], awaddr[31:ADDR_W]};

  logic [1:0]        rstate_q, rstate_d;
  logic [1:0]        wstate_q, wstate_d;
  logic              arready_q, rvalid_q, awready_q, bvalid_q;
  logic [1:0]        rresp_q, bresp_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] raddr_q, waddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;

  logic [63:0]       mtime_q, mtime_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       mtimecmp_q [NHART];
  logic [NHART-1:0]  msip_q, mtip_q;

  logic [31:0]       rd_data;
  logic              rd_err;
  logic [NHART-1:0]  wr_msip, wr_cmp_lo, wr_cmp_hi;
  logic              wr_mt_lo, wr_mt_hi, wr_err, wr_en;

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;
  assign awready = awready_q;
  assign wready  = awready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign mtip    = mtip_q;
  assign msip    = msip_q;

  assign wr_en = (wstate_q == W_ACC);

  // Read-side decode: select register contents for the latched read offset
  always_comb begin
    rd_data = 32'h0;
    rd_err  = 1'b1;
    for (int h = 0; h < NHART; h++) begin
      if (raddr_q == msip_off(h)) begin
        rd_data = {31'b0, msip_q[h]};
        rd_err  = 1'b0;
      end
      if (raddr_q == cmp_off(h)) begin
        rd_data = mtimecmp_q[h][31:0];
        rd_err  = 1'b0;
      end
      if (raddr_q == cmp_off(h) + ADDR_W'(4)) begin
        rd_data = mtimecmp_q[h][63:32];
        rd_err  = 1'b0;
      end
    end
    if (raddr_q == OFF_MTIME_LO) begin
      rd_data = mtime_q[31:0];
      rd_err  = 1'b0;
    end
    if (raddr_q == OFF_MTIME_HI) begin
      rd_data = mtime_q[63:32];
      rd_err  = 1'b0;
    end
  end

  // Write-side decode: one-hot register selects for the latched write offset
  always_comb begin
    wr_msip   = '0;
    wr_cmp_lo = '0;
    wr_cmp_hi = '0;
    for (int h = 0; h < NHART; h++) begin
      wr_msip[h]   = (waddr_q == msip_off(h));
      wr_cmp_lo[h] = (waddr_q == cmp_off(h));
      wr_cmp_hi[h] = (waddr_q == cmp_off(h) + ADDR_W'(4));
    end
    wr_mt_lo = (waddr_q == OFF_MTIME_LO);
    wr_mt_hi = (waddr_q == OFF_MTIME_HI);
    wr_err   = ~(|{wr_msip, wr_cmp_lo, wr_cmp_hi, wr_mt_lo, wr_mt_hi});
  end

  // Read channel next-state
  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (arvalid) rstate_d = R_ACC;
      R_ACC:   rstate_d = R_RESP;
      R_RESP:  if (rready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read channel registers: accept pulse, then data/response held until taken
  always_ff @(posedge clock) begin
    if (!reset) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= 32'h0;
      raddr_q   <= '0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= (rstate_q == R_IDLE) && arvalid;
      if ((rstate_q == R_IDLE) && arvalid) begin
        raddr_q <= araddr[ADDR_W-1:0];
      end
      if (rstate_q == R_ACC) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if ((rstate_q == R_RESP) && rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Write channel next-state
  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (awvalid && wvalid) wstate_d = W_ACC;
      W_ACC:   wstate_d = W_RESP;
      W_RESP:  if (bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write channel registers: address and data only accepted together
  always_ff @(posedge clock) begin
    if (!reset) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      waddr_q   <= '0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= (wstate_q == W_IDLE) && awvalid && wvalid;
      if ((wstate_q == W_IDLE) && awvalid && wvalid) begin
        waddr_q <= awaddr[ADDR_W-1:0];
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (wstate_q == W_ACC) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if ((wstate_q == W_RESP) && bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // mtime next value: a software write wins over the tick and restarts the prescaler
  always_comb begin
    mtime_d = mtime_q;
    cnt_d   = cnt_q;
    if (wr_en && (wr_mt_lo || wr_mt_hi)) begin
      cnt_d = '0;
      if (wr_mt_lo) begin
        mtime_d[31:0] = merge_bytes(mtime_q[31:0], wdata_q, wstrb_q);
      end else begin
        mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdata_q, wstrb_q);
      end
    end else if (cnt_q == CNT_MAX) begin
      mtime_d = mtime_q + 64'd1;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Timer, compare, software-interrupt and timer-interrupt state
  always_ff @(posedge clock) begin
    if (!reset) begin
      mtime_q <= 64'h0;
      cnt_q   <= '0;
      msip_q  <= '0;
      mtip_q  <= '0;
      for (int h = 0; h < NHART; h++) begin
        mtimecmp_q[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
      end
    end else begin
      mtime_q <= mtime_d;
      cnt_q   <= cnt_d;
      for (int h = 0; h < NHART; h++) begin
        mtip_q[h] <= (mtime_q >= mtimecmp_q[h]);
        if (wr_en && wr_msip[h] && wstrb_q[0]) begin
          msip_q[h] <= wdata_q[0];
        end
        if (wr_en && wr_cmp_lo[h]) begin
          mtimecmp_q[h][31:0] <= merge_bytes(mtimecmp_q[h][31:0], wdata_q, wstrb_q);
        end
        if (wr_en && wr_cmp_hi[h]) begin
          mtimecmp_q[h][63:32] <= merge_bytes(mtimecmp_q[h][63:32], wdata_q, wstrb_q);
        end
      end
    end
  end

endmodule
`default_nettype wire
